// File: rtl/lsu_mem_port.sv
// Load/store initiator for a word-wide memory port with combinational read
// data and a posedge write. It handles one byte, halfword or word access at
// a time. Loads are extended and returned, sub-word stores are done as
// read-modify-write, and bad accesses get an error response without any
// memory activity.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | ready for a request; latch and classify it on req_valid_i
// S_READ  | read the addressed word; extract load data or merge store lane
// S_WRITE | drive the aligned address and the full/merged word for one edge
// S_RESP  | one-cycle response pulse carrying err and load data
module lsu_mem_port #(
    parameter int                AWIDTH    = 32,
    parameter int                DWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h01000000,
    parameter logic [AWIDTH-1:0] MEM_BYTES = 32'h00100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [DWIDTH-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic              rsp_err_o,
    output logic [DWIDTH-1:0] rsp_rdata_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // One past the last valid byte; one extra bit so the end check cannot wrap.
    localparam logic [AWIDTH:0] LP_LIMIT = {1'b0, BASE_ADDR} + {1'b0, MEM_BYTES};

    state_t              r_state;
    state_t              w_next;

    logic                r_we;
    logic [1:0]          r_size;
    logic                r_uns;
    logic [AWIDTH-1:0]   r_addr;
    logic [DWIDTH-1:0]   r_data;
    logic                r_err;
    logic [DWIDTH-1:0]   r_rdata;

    logic [2:0]          w_nbytes;
    logic [AWIDTH:0]     w_end;
    logic                w_misalign;
    logic                w_below;
    logic                w_over;
    logic                w_req_err;
    logic                w_word_store;

    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [DWIDTH-1:0]   w_load_val;
    logic [DWIDTH-1:0]   w_merged;
    logic [AWIDTH-1:0]   w_aligned;

    // Classify the incoming request: size, alignment and range.
    always_comb begin
        w_nbytes   = 3'd4;
        w_misalign = 1'b0;
        case (req_size_i)
            SZ_BYTE: begin
                w_nbytes   = 3'd1;
                w_misalign = 1'b0;
            end
            SZ_HALF: begin
                w_nbytes   = 3'd2;
                w_misalign = req_addr_i[0];
            end
            SZ_WORD: begin
                w_nbytes   = 3'd4;
                w_misalign = (req_addr_i[1:0] != 2'b00);
            end
            default: begin
                w_nbytes   = 3'd4;
                w_misalign = 1'b1;
            end
        endcase
        w_end        = {1'b0, req_addr_i} + {{(AWIDTH-2){1'b0}}, w_nbytes};
        w_below      = (req_addr_i < BASE_ADDR);
        w_over       = (w_end > LP_LIMIT);
        w_req_err    = w_misalign | w_below | w_over;
        w_word_store = req_we_i & (req_size_i == SZ_WORD);
    end

    // Lane extraction, load extension and store-lane merge on the read word.
    always_comb begin
        w_byte = mem_data_i[7:0];
        case (r_addr[1:0])
            2'd0:    w_byte = mem_data_i[7:0];
            2'd1:    w_byte = mem_data_i[15:8];
            2'd2:    w_byte = mem_data_i[23:16];
            default: w_byte = mem_data_i[31:24];
        endcase
        w_half = r_addr[1] ? mem_data_i[31:16] : mem_data_i[15:0];

        w_load_val = mem_data_i;
        case (r_size)
            SZ_BYTE: w_load_val = {{24{w_byte[7] & ~r_uns}}, w_byte};
            SZ_HALF: w_load_val = {{16{w_half[15] & ~r_uns}}, w_half};
            default: w_load_val = mem_data_i;
        endcase

        w_merged = mem_data_i;
        if (r_size == SZ_BYTE) begin
            case (r_addr[1:0])
                2'd0:    w_merged[7:0]   = r_data[7:0];
                2'd1:    w_merged[15:8]  = r_data[7:0];
                2'd2:    w_merged[23:16] = r_data[7:0];
                default: w_merged[31:24] = r_data[7:0];
            endcase
        end else begin
            if (r_addr[1]) begin
                w_merged[31:16] = r_data[15:0];
            end else begin
                w_merged[15:0]  = r_data[15:0];
            end
        end
    end

    assign w_aligned = {r_addr[AWIDTH-1:2], 2'b00};

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decision.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    if (w_req_err) begin
                        w_next = S_RESP;
                    end else if (w_word_store) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next = S_READ;
                    end
                end
            end
            S_READ:  w_next = r_we ? S_WRITE : S_RESP;
            S_WRITE: w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request latch at acceptance, then load result or merged word from READ.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_we    <= req_we_i;
                        r_size  <= req_size_i;
                        r_uns   <= req_unsigned_i;
                        r_addr  <= req_addr_i;
                        r_data  <= req_wdata_i;
                        r_err   <= w_req_err;
                        r_rdata <= '0;
                    end
                end
                S_READ: begin
                    if (r_we) begin
                        r_data <= w_merged;
                    end else begin
                        r_rdata <= w_load_val;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Moore outputs; everything is forced low while rst is high so a write
    // cannot land at the edge that resets the block.
    always_comb begin
        req_ready_o    = 1'b0;
        rsp_valid_o    = 1'b0;
        rsp_err_o      = 1'b0;
        rsp_rdata_o    = '0;
        mem_addr_o     = '0;
        mem_data_o     = '0;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    req_ready_o = 1'b1;
                end
                S_READ: begin
                    mem_read_en_o = 1'b1;
                    mem_addr_o    = w_aligned;
                end
                S_WRITE: begin
                    mem_write_en_o = 1'b1;
                    mem_addr_o     = w_aligned;
                    mem_data_o     = r_data;
                end
                S_RESP: begin
                    rsp_valid_o = 1'b1;
                    rsp_err_o   = r_err;
                    rsp_rdata_o = r_rdata;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store initiator that drives the word-wide `memory` port (combinational read, posedge write, 32-bit little-endian) on behalf of the core's execute stage. It accepts one byte, halfword or word access at a time over a valid/ready request interface. Sub-word stores are done as read-modify-write. Loads are returned sign- or zero-extended, and misaligned or out-of-range accesses produce an error response without touching memory.

## Interface
Parameters:
- `AWIDTH`, 32, address width.
- `DWIDTH`, 32, data width; only 32 is supported.
- `BASE_ADDR`, 32'h01000000, first byte address of the attached memory.
- `MEM_BYTES`, 32'h00100000, size in bytes of the attached memory.

Ports:
- `clk` in 1: the single clock for the block.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid_i` in 1: a request is present.
- `req_ready_o` out 1: the block can accept a request this cycle.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_size_i` in 2: access size; 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned_i` in 1: zero-extend the load result (lbu/lhu).
- `req_addr_i` in AWIDTH: byte address of the access.
- `req_wdata_i` in DWIDTH: store data, right-aligned.
- `rsp_valid_o` out 1: one-cycle completion pulse.
- `rsp_err_o` out 1: error flag, qualified by `rsp_valid_o`.
- `rsp_rdata_o` out DWIDTH: extended load result, qualified by `rsp_valid_o`.
- `mem_addr_o` out AWIDTH: word-aligned address to the memory.
- `mem_data_o` out DWIDTH: write data to the memory.
- `mem_read_en_o` out 1: memory read enable.
- `mem_write_en_o` out 1: memory write enable.
- `mem_data_i` in DWIDTH: combinational read data from the memory.

## Operation
States: IDLE, READ, WRITE, RESP.

**IDLE**
- `req_ready_o` = 1.
- On `req_valid_i`, latch the request, then classify it:
  - **Error** if any of the following holds; next state RESP with err = 1:
    - size = 11;
    - half access with addr[0] = 1;
    - word access with addr[1:0] ≠ 0;
    - addr < BASE_ADDR;
    - addr + nbytes > BASE_ADDR + MEM_BYTES (computed in 33 bits, no wrap).
  - **Load** or sub-word store: next state READ.
  - **Word store**: next state WRITE, with `mem_data_o` = wdata.

**READ**
- Outputs: `mem_read_en_o` = 1, `mem_addr_o` = {addr[31:2], 2'b00}.
- Capture `mem_data_i` at the end of the cycle.
- Byte lane = addr[1:0]; half lane = addr[1].
- Load: extract the byte or half from that lane, extend it per `req_unsigned_i`, then go to RESP.
- Sub-word store: merge wdata[7:0] or wdata[15:0] into the selected lane of the captured word (other lanes unchanged), then go to WRITE.

**WRITE**
- Outputs: `mem_write_en_o` = 1, aligned `mem_addr_o`, merged `mem_data_o`.
- The memory commits at the closing edge. Next state RESP.

**RESP**
- Outputs: `rsp_valid_o` = 1 for exactly one cycle, `req_ready_o` = 0.
- `rsp_rdata_o` = load result; 0 for stores and errors.
- Next state IDLE. There is no response backpressure.

**Output defaults**
- Outside READ/WRITE: `mem_read_en_o` = `mem_write_en_o` = 0, `mem_addr_o` = 0, `mem_data_o` = 0.
- Read and write enables are never both high.

**Request interface**
- `req_ready_o` is 0 in READ, WRITE and RESP.
- A request held during those states is not accepted. It is accepted on the first IDLE cycle.
- Request inputs are sampled only at acceptance; later changes have no effect.

## Timing
- **Reset:** `rst` high at an edge forces IDLE and all outputs to 0, including `req_ready_o`. The first cycle after `rst` falls has `req_ready_o` = 1.
- **Reset mid-operation:** the operation is aborted with no response. If `rst` is high during WRITE, `mem_write_en_o` is already 0 combinationally, so no write reaches memory.
- **Latency**, counted in cycles from the acceptance cycle to `rsp_valid_o`:
  - error: 1;
  - load: 2;
  - word store: 2;
  - sub-word store: 3.
- **Throughput:** the next request is accepted the cycle after RESP. The minimum request spacing equals latency + 1.
- **Sign extension:** uses bit 7 of the byte or bit 15 of the half from the selected lane.

## Test plan
Word at 0x01000004 preloaded to 0x876543F0.
- **Byte loads:** lb @0x01000004 → rdata 0xFFFFFFF0, rsp 2 cycles after accept; lbu @0x01000004 → 0x000000F0; lbu @0x01000007 → 0x00000087.
- **Half load:** lh @0x01000006 → 0xFFFF8765. READ drives `mem_addr_o` 0x01000004 with `mem_read_en_o` = 1 for exactly one cycle.
- **Sub-word store:** sb wdata 0x123456AB @0x01000005 → READ, then WRITE with `mem_data_o` 0x8765ABF0; rsp 3 cycles after accept, err 0. A following lw @0x01000004 → 0x8765ABF0.
- **Misaligned load:** lw @0x01000002 → rsp_valid and err = 1 one cycle after accept. No mem enable is ever asserted; rdata 0.
- **Out-of-range store:** sw @0x00FFFFFC → err 1, and memory at 0x01000000 is unchanged.
- **Request gating:** `req_valid_i` held high across a word store → `req_ready_o` = 0 for 2 cycles, and the second request is accepted only after RESP.
- **Reset during sub-word store:** `rst` high during the READ cycle of an sh → no write and no response. `req_ready_o` = 1 the cycle after `rst` falls, and the target word is unchanged.
